// File: rtl/sdram_fifo_ctrl.sv
// Write/read staging FIFOs in front of an SDRAM controller, with a small
// arbiter that issues fixed-length write and read bursts over rotating address windows.
module sdram_fifo_ctrl #(
  parameter int FIFO_AW = 10
) (
  input  logic               clk,
  input  logic               rstn,
  // user write side
  input  logic               wr_fifo_wr_en,
  input  logic [15:0]        wr_fifo_wr_data,
  input  logic [23:0]        wr_b_addr,
  input  logic [23:0]        wr_e_addr,
  input  logic [9:0]         wr_burst_len,
  input  logic               wr_rst,
  // user read side
  input  logic               rd_fifo_rd_en,
  output logic [15:0]        rd_fifo_rd_data,
  input  logic [23:0]        rd_b_addr,
  input  logic [23:0]        rd_e_addr,
  input  logic [9:0]         rd_burst_len,
  input  logic               rd_rst,
  input  logic               rd_valid,
  // status
  output logic [FIFO_AW:0]   wr_fifo_num,
  output logic [FIFO_AW:0]   rd_fifo_num,
  output logic               wr_ovf,
  output logic               rd_unf,
  // controller side
  input  logic               init_end,
  output logic               wr_req,
  output logic [23:0]        wr_addr,
  output logic [15:0]        wr_data,
  input  logic               wr_ack,
  output logic               rd_req,
  output logic [23:0]        rd_addr,
  input  logic [15:0]        rd_data,
  input  logic               rd_ack
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

  state_t r_state, w_state_nxt;

  logic [15:0]        r_wmem [DEPTH];
  logic [FIFO_AW-1:0] r_wwp, r_wrp;
  logic [FIFO_AW:0]   r_wcnt;
  logic               r_wr_ovf, r_wrst_pend;

  logic [15:0]        r_rmem [DEPTH];
  logic [FIFO_AW-1:0] r_rwp, r_rrp;
  logic [FIFO_AW:0]   r_rcnt;
  logic               r_rd_unf, r_rrst_pend;

  logic               r_wr_ack_d, r_rd_ack_d;
  logic               r_wr_req, r_rd_req;
  logic [23:0]        r_wr_addr, r_rd_addr;
  logic               r_started;

  logic w_wfull, w_wempty, w_wpush, w_wpop, w_wflush;
  logic w_rfull, w_rempty, w_rpush, w_rpop, w_rflush;
  logic w_wr_qual, w_rd_qual;
  logic w_wr_rise, w_wr_fall, w_rd_rise, w_rd_fall;
  logic [23:0] w_wr_end2, w_rd_end2, w_wr_adv, w_rd_adv;

  // A flush requested mid-burst is held pending until the arbiter is back in IDLE.
  assign w_wflush = (wr_rst || r_wrst_pend) && (r_state != ST_WR);
  assign w_rflush = (rd_rst || r_rrst_pend) && (r_state != ST_RD);

  assign w_wfull  = (r_wcnt == CNT_FULL);
  assign w_wempty = (r_wcnt == '0);
  assign w_wpush  = wr_fifo_wr_en && !w_wfull && !w_wflush;
  assign w_wpop   = wr_ack && !w_wempty && !w_wflush;

  assign w_rfull  = (r_rcnt == CNT_FULL);
  assign w_rempty = (r_rcnt == '0);
  assign w_rpush  = rd_ack && !w_rfull && !w_rflush;
  assign w_rpop   = rd_fifo_rd_en && !w_rempty && !w_rflush;

  always_ff @(posedge clk) begin
    if (w_wpush) r_wmem[r_wwp] <= wr_fifo_wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wwp       <= '0;
      r_wrp       <= '0;
      r_wcnt      <= '0;
      r_wr_ovf    <= 1'b0;
      r_wrst_pend <= 1'b0;
    end else if (w_wflush) begin
      r_wwp       <= '0;
      r_wrp       <= '0;
      r_wcnt      <= '0;
      r_wr_ovf    <= 1'b0;
      r_wrst_pend <= 1'b0;
    end else begin
      if (w_wpush) r_wwp <= r_wwp + PTR_ONE;
      if (w_wpop)  r_wrp <= r_wrp + PTR_ONE;
      if (w_wpush && !w_wpop)      r_wcnt <= r_wcnt + CNT_ONE;
      else if (!w_wpush && w_wpop) r_wcnt <= r_wcnt - CNT_ONE;
      if (wr_fifo_wr_en && w_wfull) r_wr_ovf <= 1'b1;
      if (wr_rst) r_wrst_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rpush) r_rmem[r_rwp] <= rd_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rwp       <= '0;
      r_rrp       <= '0;
      r_rcnt      <= '0;
      r_rd_unf    <= 1'b0;
      r_rrst_pend <= 1'b0;
    end else if (w_rflush) begin
      r_rwp       <= '0;
      r_rrp       <= '0;
      r_rcnt      <= '0;
      r_rd_unf    <= 1'b0;
      r_rrst_pend <= 1'b0;
    end else begin
      if (w_rpush) r_rwp <= r_rwp + PTR_ONE;
      if (w_rpop)  r_rrp <= r_rrp + PTR_ONE;
      if (w_rpush && !w_rpop)      r_rcnt <= r_rcnt + CNT_ONE;
      else if (!w_rpush && w_rpop) r_rcnt <= r_rcnt - CNT_ONE;
      if (rd_fifo_rd_en && w_rempty) r_rd_unf <= 1'b1;
      if (rd_rst) r_rrst_pend <= 1'b1;
    end
  end

  assign w_wr_qual = init_end && (wr_burst_len != 10'd0) && !w_wflush &&
                     (32'(r_wcnt) >= 32'(wr_burst_len));
  assign w_rd_qual = init_end && rd_valid && (rd_burst_len != 10'd0) && !w_rflush &&
                     ((32'(r_rcnt) + 32'(rd_burst_len)) <= 32'(DEPTH));

  assign w_wr_rise = wr_ack && !r_wr_ack_d;
  assign w_wr_fall = !wr_ack && r_wr_ack_d;
  assign w_rd_rise = rd_ack && !r_rd_ack_d;
  assign w_rd_fall = !rd_ack && r_rd_ack_d;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_qual)      w_state_nxt = ST_WR;
        else if (w_rd_qual) w_state_nxt = ST_RD;
      end
      ST_WR:   if (w_wr_fall) w_state_nxt = ST_IDLE;
      ST_RD:   if (w_rd_fall) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_wr_ack_d <= 1'b0;
      r_rd_ack_d <= 1'b0;
      r_wr_req   <= 1'b0;
      r_rd_req   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ack_d <= wr_ack;
      r_rd_ack_d <= rd_ack;
      if (r_state == ST_IDLE && w_state_nxt == ST_WR)
        r_wr_req <= 1'b1;
      else if (r_state == ST_WR && (w_wr_rise || w_wr_fall))
        r_wr_req <= 1'b0;
      if (r_state == ST_IDLE && w_state_nxt == ST_RD)
        r_rd_req <= 1'b1;
      else if (r_state == ST_RD && (w_rd_rise || w_rd_fall))
        r_rd_req <= 1'b0;
    end
  end

  // Wrap to the region start when a following burst would not fit below the end address.
  assign w_wr_end2 = r_wr_addr + {13'd0, wr_burst_len, 1'b0};
  assign w_rd_end2 = r_rd_addr + {13'd0, rd_burst_len, 1'b0};
  assign w_wr_adv  = (w_wr_end2 > wr_e_addr) ? wr_b_addr : r_wr_addr + {14'd0, wr_burst_len};
  assign w_rd_adv  = (w_rd_end2 > rd_e_addr) ? rd_b_addr : r_rd_addr + {14'd0, rd_burst_len};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_started <= 1'b0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
    end else begin
      r_started <= 1'b1;
      if (!r_started || w_wflush)            r_wr_addr <= wr_b_addr;
      else if (r_state == ST_WR && w_wr_fall) r_wr_addr <= w_wr_adv;
      if (!r_started || w_rflush)            r_rd_addr <= rd_b_addr;
      else if (r_state == ST_RD && w_rd_fall) r_rd_addr <= w_rd_adv;
    end
  end

  assign wr_data         = r_wmem[r_wrp];
  assign rd_fifo_rd_data = r_rmem[r_rrp];
  assign wr_fifo_num     = r_wcnt;
  assign rd_fifo_num     = r_rcnt;
  assign wr_ovf          = r_wr_ovf;
  assign rd_unf          = r_rd_unf;
  assign wr_req          = r_wr_req;
  assign rd_req          = r_rd_req;
  assign wr_addr         = r_wr_addr;
  assign rd_addr         = r_rd_addr;

endmodule
